// File: rtl/sram_blit_engine.sv
// Block FILL / COPY engine mastering the 32-bit toggle-handshake GPU port of the SRAM arbiter.
// Exactly one read or write is outstanding at a time; COPY alternates read/write per word.
module sram_blit_engine #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic              cmd_copy,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [31:0]       cmd_fill,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_rdreq,
  input  logic              mem_rdack,
  output logic              mem_wrreq,
  input  logic              mem_wrack
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  typedef struct packed {
    logic              copy;
    logic [31:0]       fill;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [CNT_W-1:0]  count;
  } ctx_t;

  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state, state_n;
  ctx_t              ctx, ctx_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       wdata_n;
  logic              rdreq_n, wrreq_n;
  logic              rd_pend, wr_pend;
  logic [ADDR_W-1:0] src_al, dst_al;

  assign rd_pend = (mem_rdreq != mem_rdack);
  assign wr_pend = (mem_wrreq != mem_wrack);
  assign src_al  = cmd_src & ALIGN_MASK;
  assign dst_al  = cmd_dst & ALIGN_MASK;

  // Busy also covers a handshake left unmatched by a reset mid-transfer.
  assign busy = (state != IDLE) || rd_pend || wr_pend;
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ctx       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rdreq <= 1'b0;
      mem_wrreq <= 1'b0;
    end else begin
      state     <= state_n;
      ctx       <= ctx_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_rdreq <= rdreq_n;
      mem_wrreq <= wrreq_n;
    end
  end

  always_comb begin
    state_n = state;
    ctx_n   = ctx;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    rdreq_n = mem_rdreq;
    wrreq_n = mem_wrreq;
    case (state)
      IDLE: begin
        // Track the arbiter's ack so a stale handshake drains without a new request.
        rdreq_n = mem_rdack;
        wrreq_n = mem_wrack;
        if (cmd_start && !rd_pend && !wr_pend) begin
          ctx_n.copy  = cmd_copy;
          ctx_n.fill  = cmd_fill;
          ctx_n.src   = src_al;
          ctx_n.dst   = dst_al;
          ctx_n.count = cmd_count;
          if (cmd_count == '0) begin
            state_n = DONE;
          end else if (cmd_copy) begin
            addr_n  = src_al;
            rdreq_n = ~mem_rdreq;
            state_n = RD_WAIT;
          end else begin
            addr_n  = dst_al;
            wdata_n = cmd_fill;
            wrreq_n = ~mem_wrreq;
            state_n = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!rd_pend) begin
          addr_n    = ctx.dst;
          wdata_n   = mem_rdata;
          wrreq_n   = ~mem_wrreq;
          ctx_n.src = ctx.src + WORD_STEP;
          state_n   = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (!wr_pend) begin
          ctx_n.dst   = ctx.dst + WORD_STEP;
          ctx_n.count = ctx.count - CNT_W'(1);
          if (ctx.count == CNT_W'(1)) begin
            state_n = DONE;
          end else if (ctx.copy) begin
            // src was already advanced when the previous read completed.
            addr_n  = ctx.src;
            rdreq_n = ~mem_rdreq;
            state_n = RD_WAIT;
          end else begin
            addr_n  = ctx.dst + WORD_STEP;
            wdata_n = ctx.fill;
            wrreq_n = ~mem_wrreq;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_blit_engine.sv
// Directed bench for sram_blit_engine with a toggle-handshake arbiter model of programmable ack latency.
module tb_sram_blit_engine;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_start = 1'b0;
  logic              cmd_copy = 1'b0;
  logic [ADDR_W-1:0] cmd_src = '0;
  logic [ADDR_W-1:0] cmd_dst = '0;
  logic [CNT_W-1:0]  cmd_count = '0;
  logic [31:0]       cmd_fill = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic              mem_rdreq, mem_wrreq;
  logic              mem_rdack = 1'b0;
  logic              mem_wrack = 1'b0;

  int checks = 0;
  int passes = 0;

  sram_blit_engine #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_copy(cmd_copy), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rdreq(mem_rdreq), .mem_rdack(mem_rdack),
    .mem_wrreq(mem_wrreq), .mem_wrack(mem_wrack)
  );

  always #5 clk = ~clk;

  // Arbiter model: commits to a request when it sees req!=ack, acks after lat edges,
  // and ignores the edge right after its own ack.
  logic [31:0]       mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] rd_a_log[$];
  logic [ADDR_W-1:0] wr_a_log[$];
  logic [31:0]       wr_d_log[$];
  bit                op_log[$];
  int                lat = 1;
  logic              rd_infl = 1'b0, wr_infl = 1'b0, rd_cool = 1'b0, wr_cool = 1'b0;
  logic              rd_tgt = 1'b0, wr_tgt = 1'b0;
  int                rd_wait = 0, wr_wait = 0;
  logic [ADDR_W-1:0] rd_a = '0, wr_a = '0;
  logic [31:0]       wr_d = '0;

  function automatic logic [31:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    rd_cool <= 1'b0;
    if (rd_infl) begin
      if (rd_wait >= lat - 1) begin
        mem_rdata <= mem_rd(rd_a);
        mem_rdack <= rd_tgt;
        rd_infl   <= 1'b0;
        rd_cool   <= 1'b1;
        rd_a_log.push_back(rd_a);
        op_log.push_back(1'b0);
      end else rd_wait <= rd_wait + 1;
    end else if (!rd_cool && (mem_rdreq != mem_rdack)) begin
      if (lat <= 1) begin
        mem_rdata <= mem_rd(mem_addr);
        mem_rdack <= mem_rdreq;
        rd_cool   <= 1'b1;
        rd_a_log.push_back(mem_addr);
        op_log.push_back(1'b0);
      end else begin
        rd_infl <= 1'b1;
        rd_tgt  <= mem_rdreq;
        rd_a    <= mem_addr;
        rd_wait <= 1;
      end
    end
  end

  always @(posedge clk) begin
    wr_cool <= 1'b0;
    if (wr_infl) begin
      if (wr_wait >= lat - 1) begin
        mem[wr_a] = wr_d;
        mem_wrack <= wr_tgt;
        wr_infl   <= 1'b0;
        wr_cool   <= 1'b1;
        wr_a_log.push_back(wr_a);
        wr_d_log.push_back(wr_d);
        op_log.push_back(1'b1);
      end else wr_wait <= wr_wait + 1;
    end else if (!wr_cool && (mem_wrreq != mem_wrack)) begin
      if (lat <= 1) begin
        mem[mem_addr] = mem_wdata;
        mem_wrack <= mem_wrreq;
        wr_cool   <= 1'b1;
        wr_a_log.push_back(mem_addr);
        wr_d_log.push_back(mem_wdata);
        op_log.push_back(1'b1);
      end else begin
        wr_infl <= 1'b1;
        wr_tgt  <= mem_wrreq;
        wr_a    <= mem_addr;
        wr_d    <= mem_wdata;
        wr_wait <= 1;
      end
    end
  end

  // Protocol monitor: done pulses, both channels pending at once, unaligned address.
  int done_cnt = 0;
  int viol = 0;
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
    if ((mem_rdreq !== mem_rdack) && (mem_wrreq !== mem_wrack) && reset_n) viol++;
    if (reset_n && mem_addr[1:0] !== 2'b00) viol++;
  end

  task automatic start_cmd(input logic copy, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                           input logic [CNT_W-1:0] cnt, input logic [31:0] fill);
    @(negedge clk);
    cmd_copy = copy; cmd_src = src; cmd_dst = dst; cmd_count = cnt; cmd_fill = fill;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output bit timeout);
    cyc = 1;
    while (done !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    timeout = (done !== 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (mem_addr !== 24'h0) $display("FAIL reset_addr got %h want 0", mem_addr); else passes++;
    checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", mem_wdata); else passes++;
    checks++; if ({mem_rdreq, mem_wrreq} !== 2'b00) $display("FAIL reset_reqs got %b want 00", {mem_rdreq, mem_wrreq}); else passes++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_copy();
    int wb, db, cyc, bcnt;
    bit to;
    lat = 3;
    mem[24'h000300] = 32'h5A5A0001;
    start_cmd(1'b1, 24'h000300, 24'h000500, 16'd4, 32'h0);
    for (int i = 0; i < 10 && !rd_infl; i++) @(negedge clk);
    checks++; if (rd_infl !== 1'b1) $display("FAIL rst_mid_read_seen got %b want 1", rd_infl); else passes++;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_rdreq, mem_wrreq} !== 4'b0000 || mem_addr !== 24'h0 || mem_wdata !== 32'h0)
      $display("FAIL rst_mid_outputs got busy=%b done=%b rq=%b wq=%b addr=%h wd=%h want all 0",
               busy, done, mem_rdreq, mem_wrreq, mem_addr, mem_wdata);
    else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
    end
    checks++; if (bcnt != 1) $display("FAIL rst_mid_busy_cycles got %0d want 1", bcnt); else passes++;
    checks++; if (mem_rdreq !== mem_rdack) $display("FAIL rst_mid_resync got rq=%b ack=%b want equal", mem_rdreq, mem_rdack); else passes++;
    checks++; if (mem_rd(24'h000500) !== 32'h0) $display("FAIL rst_mid_no_write got %h want 0", mem_rd(24'h000500)); else passes++;
    wb = wr_a_log.size(); db = done_cnt;
    start_cmd(1'b0, 24'h0, 24'h000040, 16'd2, 32'hCAFEF00D);
    wait_done(200, cyc, to);
    checks++; if (to) $display("FAIL rst_mid_fill_timeout got timeout want done"); else passes++;
    @(negedge clk);
    checks++;
    if (wr_a_log.size() - wb != 2 || wr_a_log[wb] !== 24'h000040 || wr_a_log[wb+1] !== 24'h000044)
      $display("FAIL rst_mid_fill_addrs got n=%0d want 0x40,0x44", wr_a_log.size() - wb);
    else passes++;
    checks++;
    if (mem_rd(24'h000040) !== 32'hCAFEF00D || mem_rd(24'h000044) !== 32'hCAFEF00D)
      $display("FAIL rst_mid_fill_data got %h %h want cafef00d", mem_rd(24'h000040), mem_rd(24'h000044));
    else passes++;
    checks++; if (done_cnt - db != 1) $display("FAIL rst_mid_done_pulses got %0d want 1", done_cnt - db); else passes++;
  endtask

  task automatic test_fill();
    int wb, rb, db, vb, cyc;
    bit to;
    logic [ADDR_W-1:0] ea [4] = '{24'h000100, 24'h000104, 24'h000108, 24'h00010C};
    lat = 1;
    wb = wr_a_log.size(); rb = rd_a_log.size(); db = done_cnt; vb = viol;
    start_cmd(1'b0, 24'h0, 24'h000100, 16'd4, 32'hDEADBEEF);
    wait_done(200, cyc, to);
    checks++; if (to || cyc != 9) $display("FAIL fill_latency got %0d (timeout=%0b) want 9", cyc, to); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL fill_busy_in_done got %b want 1", busy); else passes++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL fill_busy_after got %b want 0", busy); else passes++;
    checks++; if (wr_a_log.size() - wb != 4) $display("FAIL fill_wr_count got %0d want 4", wr_a_log.size() - wb); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb + i >= wr_a_log.size() || wr_a_log[wb+i] !== ea[i] || wr_d_log[wb+i] !== 32'hDEADBEEF)
        $display("FAIL fill_word%0d got %h/%h want %h/deadbeef", i, wr_a_log[wb+i], wr_d_log[wb+i], ea[i]);
      else passes++;
    end
    checks++; if (rd_a_log.size() != rb) $display("FAIL fill_no_reads got %0d want 0", rd_a_log.size() - rb); else passes++;
    checks++; if (done_cnt - db != 1) $display("FAIL fill_done_pulses got %0d want 1", done_cnt - db); else passes++;
    checks++; if (viol != vb) $display("FAIL fill_protocol got %0d violations want 0", viol - vb); else passes++;
  endtask

  task automatic test_copy();
    int wb, rb, ob, db, vb, cyc;
    bit to;
    logic [5:0] seq;
    logic [31:0] ed [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    lat = 1;
    mem[24'h000200] = 32'h11111111;
    mem[24'h000204] = 32'h22222222;
    mem[24'h000208] = 32'h33333333;
    wb = wr_a_log.size(); rb = rd_a_log.size(); ob = op_log.size(); db = done_cnt; vb = viol;
    start_cmd(1'b1, 24'h000202, 24'h000401, 16'd3, 32'hFFFFFFFF);
    wait_done(200, cyc, to);
    checks++; if (to || cyc != 13) $display("FAIL copy_latency got %0d (timeout=%0b) want 13", cyc, to); else passes++;
    @(negedge clk);
    seq = '0;
    for (int i = 0; i < 6; i++) if (ob + i < op_log.size()) seq[i] = op_log[ob+i];
    checks++;
    if (op_log.size() - ob != 6 || seq !== 6'b101010)
      $display("FAIL copy_order got n=%0d seq=%b want n=6 seq=101010", op_log.size() - ob, seq);
    else passes++;
    checks++;
    if (rd_a_log[rb] !== 24'h000200 || rd_a_log[rb+1] !== 24'h000204 || rd_a_log[rb+2] !== 24'h000208)
      $display("FAIL copy_rd_addrs got %h %h %h want 200 204 208", rd_a_log[rb], rd_a_log[rb+1], rd_a_log[rb+2]);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_rd(24'h000400 + 24'(4*i)) !== ed[i] || wr_a_log[wb+i] !== 24'h000400 + 24'(4*i))
        $display("FAIL copy_word%0d got %h at %h want %h", i, mem_rd(24'h000400 + 24'(4*i)), wr_a_log[wb+i], ed[i]);
      else passes++;
    end
    checks++; if (done_cnt - db != 1) $display("FAIL copy_done_pulses got %0d want 1", done_cnt - db); else passes++;
    checks++; if (viol != vb) $display("FAIL copy_protocol got %0d violations want 0", viol - vb); else passes++;
  endtask

  task automatic test_zero_count();
    logic rq0, wq0;
    int wb, rb;
    rq0 = mem_rdreq; wq0 = mem_wrreq; wb = wr_a_log.size(); rb = rd_a_log.size();
    start_cmd(1'b0, 24'h0, 24'h000600, 16'd0, 32'h12345678);
    checks++; if ({done, busy} !== 2'b11) $display("FAIL zero_done_cycle got done=%b busy=%b want 1 1", done, busy); else passes++;
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) $display("FAIL zero_after got done=%b busy=%b want 0 0", done, busy); else passes++;
    checks++;
    if (mem_rdreq !== rq0 || mem_wrreq !== wq0 || wr_a_log.size() != wb || rd_a_log.size() != rb)
      $display("FAIL zero_no_toggle got rq=%b wq=%b want rq=%b wq=%b", mem_rdreq, mem_wrreq, rq0, wq0);
    else passes++;
  endtask

  task automatic test_ignore_start();
    int wb, rb, db, cyc, bad;
    bit to;
    lat = 1;
    wb = wr_a_log.size(); rb = rd_a_log.size(); db = done_cnt;
    start_cmd(1'b0, 24'h0, 24'h000800, 16'd8, 32'hA5A5A5A5);
    repeat (4) @(negedge clk);
    start_cmd(1'b1, 24'h000200, 24'h000900, 16'd2, 32'h12345678);
    wait_done(200, cyc, to);
    checks++; if (to) $display("FAIL ignore_timeout got timeout want done"); else passes++;
    repeat (4) @(negedge clk);
    checks++; if (wr_a_log.size() - wb != 8) $display("FAIL ignore_wr_count got %0d want 8", wr_a_log.size() - wb); else passes++;
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (wr_a_log[wb+i] !== 24'h000800 + 24'(4*i) || wr_d_log[wb+i] !== 32'hA5A5A5A5) bad++;
    checks++; if (bad != 0) $display("FAIL ignore_words got %0d bad words want 0", bad); else passes++;
    checks++; if (rd_a_log.size() != rb) $display("FAIL ignore_no_reads got %0d want 0", rd_a_log.size() - rb); else passes++;
    checks++; if (done_cnt - db != 1) $display("FAIL ignore_done_pulses got %0d want 1", done_cnt - db); else passes++;
  endtask

  task automatic test_wrap();
    int wb, cyc;
    bit to;
    logic [ADDR_W-1:0] ea [4] = '{24'hFFFFF8, 24'hFFFFFC, 24'h000000, 24'h000004};
    lat = 1;
    wb = wr_a_log.size();
    start_cmd(1'b0, 24'h0, 24'hFFFFF8, 16'd4, 32'h0BADF00D);
    wait_done(200, cyc, to);
    @(negedge clk);
    checks++; if (to || wr_a_log.size() - wb != 4) $display("FAIL wrap_count got %0d want 4", wr_a_log.size() - wb); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_a_log[wb+i] !== ea[i] || wr_d_log[wb+i] !== 32'h0BADF00D)
        $display("FAIL wrap_word%0d got %h/%h want %h/0badf00d", i, wr_a_log[wb+i], wr_d_log[wb+i], ea[i]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_copy();
    test_fill();
    test_copy();
    test_zero_count();
    test_ignore_start();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end

endmodule
